// File: rtl/param_cc_encoder.sv
// Parameter record to MIDI CC encoder.
// Shadows each field, marks changes dirty and drains them as 3-byte CC messages.
package PARAMETER;
  typedef struct packed {
    logic [6:0] volume;
    logic [6:0] unison_detune;
    logic [6:0] attack_time;
    logic [6:0] decay_time;
    logic [6:0] sustain_level;
    logic [6:0] release_time;
    logic [6:0] tempo;
    logic [1:0] wave;
    logic       dispatcher_mode;
    logic [2:0] arp_mode;
    logic [2:0] arp_rate;
    logic [1:0] arp_rhythm;
  } parameter_t;
endpackage

module param_cc_encoder
  import PARAMETER::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  parameter_t parameters,
  input  logic       dump_req,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE, STATUS, NUMBER, VALUE
  } state_t;

  localparam logic [6:0] CC_NUM [12] = '{
    7'd7,  7'd94, 7'd73, 7'd75,
    7'd79, 7'd72, 7'd14, 7'd15,
    7'd16, 7'd17, 7'd18, 7'd19
  };

  state_t     r_state;
  state_t     w_next;
  logic [11:0] r_dirty;
  logic [6:0] r_shadow [12];
  logic [6:0] r_cc;
  logic [6:0] r_val;
  logic [7:0] r_tx_data;
  logic       r_tx_valid;

  logic [6:0] w_field [12];
  logic [3:0] w_sel_idx;
  logic [11:0] w_sel;
  logic       w_take;
  logic [7:0] w_tx_data;
  logic       w_tx_valid;
  logic       w_hs;

  always_comb begin
    w_field[0]  = parameters.volume;
    w_field[1]  = parameters.unison_detune;
    w_field[2]  = parameters.attack_time;
    w_field[3]  = parameters.decay_time;
    w_field[4]  = parameters.sustain_level;
    w_field[5]  = parameters.release_time;
    w_field[6]  = parameters.tempo;
    w_field[7]  = {5'd0, parameters.wave};
    w_field[8]  = {6'd0, parameters.dispatcher_mode};
    w_field[9]  = {4'd0, parameters.arp_mode};
    w_field[10] = {4'd0, parameters.arp_rate};
    w_field[11] = {5'd0, parameters.arp_rhythm};
  end

  // Lowest dirty index wins; scan high to low so the last hit is lowest.
  always_comb begin
    w_sel_idx = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (r_dirty[i]) w_sel_idx = 4'(i);
    end
    w_take = (r_state == IDLE) && (|r_dirty);
    w_sel = '0;
    if (w_take) w_sel[w_sel_idx] = 1'b1;
  end

  assign w_hs = r_tx_valid && tx_ready;

  always_comb begin
    w_next     = r_state;
    w_tx_data  = r_tx_data;
    w_tx_valid = r_tx_valid;
    unique case (r_state)
      IDLE: begin
        w_tx_valid = 1'b0;
        if (w_take) begin
          w_next     = STATUS;
          w_tx_data  = {4'hB, CHANNEL};
          w_tx_valid = 1'b1;
        end
      end
      STATUS: begin
        if (w_hs) begin
          w_next    = NUMBER;
          w_tx_data = {1'b0, r_cc};
        end
      end
      NUMBER: begin
        if (w_hs) begin
          w_next    = VALUE;
          w_tx_data = {1'b0, r_val};
        end
      end
      VALUE: begin
        if (w_hs) begin
          w_next     = IDLE;
          w_tx_valid = 1'b0;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_cc       <= '0;
      r_val      <= '0;
    end else begin
      r_state    <= w_next;
      r_tx_data  <= w_tx_data;
      r_tx_valid <= w_tx_valid;
      if (w_take) begin
        r_cc  <= CC_NUM[w_sel_idx];
        r_val <= w_field[w_sel_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dirty <= '0;
      for (int i = 0; i < 12; i++) r_shadow[i] <= '0;
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (w_sel[i]) begin
          r_shadow[i] <= w_field[i];
          r_dirty[i]  <= dump_req;
        end else begin
          r_dirty[i] <= r_dirty[i] | dump_req
                      | (w_field[i] != r_shadow[i]);
        end
      end
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = (r_state != IDLE) | (|r_dirty);

endmodule

// File: tb/tb_param_cc_encoder.sv
// Directed bench for param_cc_encoder.
// Two instances (channel 0 and 3) share one stimulus stream.
module tb_param_cc_encoder;
  import PARAMETER::*;

  logic       clk;
  logic       reset;
  parameter_t prm;
  logic       dump_req;
  logic       tx_ready;
  logic [7:0] d0, d3;
  logic       v0, v3;
  logic       b0, b3;

  int n_vec;
  int n_err;

  param_cc_encoder #(.CHANNEL(4'd0)) u_ch0 (
    .clk(clk), .reset(reset), .parameters(prm),
    .dump_req(dump_req), .tx_data(d0), .tx_valid(v0),
    .tx_ready(tx_ready), .busy(b0)
  );

  param_cc_encoder #(.CHANNEL(4'd3)) u_ch3 (
    .clk(clk), .reset(reset), .parameters(prm),
    .dump_req(dump_req), .tx_data(d3), .tx_valid(v3),
    .tx_ready(tx_ready), .busy(b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] exp);
    chk({tag, "_v"}, {7'd0, v0}, 8'd1);
    chk({tag, "_d"}, d0, exp);
  endtask

  logic [6:0] dcc [12];
  logic [6:0] dval [12];

  initial begin
    n_vec = 0;
    n_err = 0;
    prm = '0;
    dump_req = 1'b0;
    tx_ready = 1'b1;
    reset = 1'b1;
    dcc = '{7'h07, 7'h5E, 7'h49, 7'h4B, 7'h4F, 7'h48,
            7'h0E, 7'h0F, 7'h10, 7'h11, 7'h12, 7'h13};
    dval = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66,
             7'h77, 7'h02, 7'h01, 7'h05, 7'h06, 7'h01};
    tick; tick;
    chk("rst_valid", {7'd0, v0}, 8'd0);
    chk("rst_data", d0, 8'h00);
    chk("rst_busy", {7'd0, b0}, 8'd0);
    reset = 1'b0;

    // all-zero parameters: silent
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("zero_valid", {7'd0, v0}, 8'd0);
      chk("zero_busy", {7'd0, b0}, 8'd0);
    end

    // volume 0 -> 100
    prm.volume = 7'd100;
    tick;
    chk("vol_n1_valid", {7'd0, v0}, 8'd0);
    chk("vol_n1_busy", {7'd0, b0}, 8'd1);
    tick; chk_byte("vol_st", 8'hB0);
    tick; chk_byte("vol_cc", 8'h07);
    tick; chk_byte("vol_val", 8'h64);
    tick;
    chk("vol_idle_v", {7'd0, v0}, 8'd0);
    chk("vol_idle_b", {7'd0, b0}, 8'd0);

    // wave and tempo same cycle: tempo first
    prm.wave = 2'd3;
    prm.tempo = 7'd120;
    tick;
    tick; chk_byte("tmp_st", 8'hB0);
    tick; chk_byte("tmp_cc", 8'h0E);
    tick; chk_byte("tmp_val", 8'h78);
    tick; chk("gap_v", {7'd0, v0}, 8'd0);
    chk("gap_busy", {7'd0, b0}, 8'd1);
    tick; chk_byte("wav_st", 8'hB0);
    tick; chk_byte("wav_cc", 8'h0F);
    tick; chk_byte("wav_val", 8'h03);
    tick;
    chk("wav_idle_v", {7'd0, v0}, 8'd0);
    chk("wav_idle_b", {7'd0, b0}, 8'd0);

    // backpressure during NUMBER
    prm.attack_time = 7'd5;
    tick;
    tick; chk_byte("atk_st", 8'hB0);
    tick; chk_byte("atk_cc", 8'h49);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick; chk_byte("atk_hold", 8'h49);
    end
    tx_ready = 1'b1;
    tick; chk_byte("atk_val", 8'h05);
    tick; chk("atk_idle_v", {7'd0, v0}, 8'd0);

    // new values for every field, then drain
    prm.volume = 7'h11; prm.unison_detune = 7'h22;
    prm.attack_time = 7'h33; prm.decay_time = 7'h44;
    prm.sustain_level = 7'h55; prm.release_time = 7'h66;
    prm.tempo = 7'h77; prm.wave = 2'd2;
    prm.dispatcher_mode = 1'b1; prm.arp_mode = 3'd5;
    prm.arp_rate = 3'd6; prm.arp_rhythm = 2'd1;
    tick;
    for (int i = 0; i < 200 && b0; i++) tick;
    chk("drain_busy", {7'd0, b0}, 8'd0);

    // dump: 12 messages in index order, 4 cycles each
    dump_req = 1'b1;
    tick;
    dump_req = 1'b0;
    tick;
    for (int m = 0; m < 12; m++) begin
      chk_byte("dmp_st", 8'hB0);
      chk("dmp_st3", d3, 8'hB3);
      chk("dmp_st3_v", {7'd0, v3}, 8'd1);
      tick; chk_byte("dmp_cc", {1'b0, dcc[m]});
      tick; chk_byte("dmp_val", {1'b0, dval[m]});
      tick; chk("dmp_idle", {7'd0, v0}, 8'd0);
      tick;
    end
    chk("dmp_end_v", {7'd0, v0}, 8'd0);
    chk("dmp_end_b", {7'd0, b0}, 8'd0);

    // release 10 -> 20 -> 30 while the 10 message is in flight
    prm.release_time = 7'd10;
    tick;
    tick; chk_byte("rel_st", 8'hB0);
    prm.release_time = 7'd20;
    tick; chk_byte("rel_cc", 8'h48);
    prm.release_time = 7'd30;
    tick; chk_byte("rel_val", 8'h0A);
    tick; chk("rel_gap", {7'd0, v0}, 8'd0);
    tick; chk_byte("rel2_st", 8'hB0);
    tick; chk_byte("rel2_cc", 8'h48);
    tick; chk_byte("rel2_val", 8'h1E);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rel_quiet_v", {7'd0, v0}, 8'd0);
      chk("rel_quiet_b", {7'd0, b0}, 8'd0);
    end

    // async reset mid-STATUS
    prm.volume = 7'd1;
    tick;
    tick; chk_byte("ar_st", 8'hB0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", {7'd0, v0}, 8'd0);
    chk("ar_valid3", {7'd0, v3}, 8'd0);
    chk("ar_busy", {7'd0, b0}, 8'd0);
    tick;
    reset = 1'b0;
    tick;
    chk("ar_post_v", {7'd0, v0}, 8'd0);
    chk("ar_post_b", {7'd0, b0}, 8'd1);
    tick; chk_byte("ar_re_st", 8'hB0);
    tick; chk_byte("ar_re_cc", 8'h07);
    tick; chk_byte("ar_re_val", 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
